// File: rtl/axi_rd_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_rd_arb
// Purpose  : Two-master AXI read arbiter with address-window decode and
//            locally generated DECERR bursts for out-of-window reads.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arb #(
    parameter int          ADDR_WTH  = 32,
    parameter int          DATA_WTH  = 256,
    parameter int          ID_WIDTH  = 4,
    parameter logic [63:0] WIN0_BASE = 64'h8000_0000,
    parameter logic [63:0] WIN1_BASE = 64'h8020_0000,
    parameter logic [63:0] WIN_SIZE  = 64'h1_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [1:0]            m_arvalid,
    output logic [1:0]            m_arready,
    input  logic [2*ADDR_WTH-1:0] m_araddr,
    input  logic [15:0]           m_arlen,
    output logic [1:0]            m_rvalid,
    input  logic [1:0]            m_rready,
    output logic [DATA_WTH-1:0]   m_rdata,
    output logic                  m_rlast,
    output logic [1:0]            m_rresp,

    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [ADDR_WTH-1:0]   s_araddr,
    output logic [7:0]            s_arlen,
    output logic [ID_WIDTH-1:0]   s_arid,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_WTH-1:0]   s_rdata,
    input  logic                  s_rlast,
    input  logic [1:0]            s_rresp,
    input  logic [ID_WIDTH-1:0]   s_rid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t              state;
    logic                grant;
    logic                last_grant;
    logic [ADDR_WTH-1:0] addr;
    logic [7:0]          len;
    logic [7:0]          cnt;

    logic [1:0]          winner;
    logic                sel;
    logic                accept;
    logic [ADDR_WTH-1:0] sel_addr;
    logic [7:0]          sel_len;

    // 65-bit compare so BASE+SIZE cannot wrap for any parameterisation.
    function automatic logic in_window(input logic [ADDR_WTH-1:0] a);
        logic [64:0] a_ext;
        logic        hit0;
        logic        hit1;
        a_ext = 65'(a);
        hit0  = (a_ext >= 65'(WIN0_BASE)) && (a_ext < 65'(WIN0_BASE) + 65'(WIN_SIZE));
        hit1  = (a_ext >= 65'(WIN1_BASE)) && (a_ext < 65'(WIN1_BASE) + 65'(WIN_SIZE));
        return hit0 || hit1;
    endfunction

    always_comb begin
        winner = 2'b00;
        case (m_arvalid)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last_grant ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

    assign m_arready = (state == IDLE && !rst_i) ? winner : 2'b00;
    assign accept    = |m_arready;
    assign sel       = winner[1];
    assign sel_addr  = sel ? m_araddr[2*ADDR_WTH-1:ADDR_WTH] : m_araddr[ADDR_WTH-1:0];
    assign sel_len   = sel ? m_arlen[15:8] : m_arlen[7:0];

    assign s_arvalid = (state == ADDR);
    assign s_araddr  = addr;
    assign s_arlen   = len;
    assign s_arid    = ID_WIDTH'(grant);
    assign s_arsize  = 3'($clog2(DATA_WTH / 8));
    assign s_arburst = 2'b01;

    always_comb begin
        m_rvalid = 2'b00;
        s_rready = 1'b0;
        m_rdata  = '0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        case (state)
            DATA: begin
                m_rvalid[grant] = s_rvalid;
                s_rready        = m_rready[grant];
                m_rdata         = s_rdata;
                m_rlast         = s_rlast;
                m_rresp         = (s_rid != s_arid) ? 2'b10 : s_rresp;
            end
            ERR: begin
                m_rvalid[grant] = 1'b1;
                m_rlast         = (cnt == len);
                m_rresp         = 2'b11;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            addr       <= '0;
            len        <= 8'd0;
            cnt        <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant <= sel;
                        addr  <= sel_addr;
                        len   <= sel_len;
                        cnt   <= 8'd0;
                        state <= in_window(sel_addr) ? ADDR : ERR;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid && s_rready) begin
                        cnt <= cnt + 8'd1;
                        if (s_rlast) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                ERR: begin
                    if (m_rready[grant]) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == len) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arb
// Purpose  : Directed self-checking bench for axi_rd_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arb;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [1:0]   m_arvalid, m_arready, m_rvalid, m_rready;
    logic [63:0]  m_araddr;
    logic [15:0]  m_arlen;
    logic [255:0] m_rdata, s_rdata;
    logic         m_rlast, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [1:0]   m_rresp, s_rresp, s_arburst;
    logic [31:0]  s_araddr;
    logic [7:0]   s_arlen;
    logic [3:0]   s_arid, s_rid;
    logic [2:0]   s_arsize;

    int n_tests = 0;
    int n_fail  = 0;

    axi_rd_arb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rresp(m_rresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arid(s_arid), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rresp(s_rresp), .s_rid(s_rid)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int m, input int b);
        return {8{32'hD000_0000 + 32'(m * 256 + b)}};
    endfunction

    // Called at negedge+1 of an IDLE cycle; returns at negedge+1 of the
    // first IDLE cycle after the burst, so back-to-back calls run at
    // minimum latency.
    task automatic run_burst(input int m, input logic [31:0] addr, input int len,
                             input logic [3:0] rid, input logic [1:0] sresp,
                             input bit err, input logic [1:0] other, input int stall_beat);
        logic [1:0] me;
        logic [1:0] exp_resp;
        int         beat;
        int         stalls;
        bit         stalled;
        me       = 2'(1 << m);
        exp_resp = (rid != 4'(m)) ? 2'b10 : sresp;
        m_arvalid = me | other;
        m_araddr  = {2{32'h8000_0000}};
        m_araddr[m*32 +: 32] = addr;
        m_arlen[m*8 +: 8]    = len[7:0];
        #1 check("arready_grant", m_arready, me);
        @(negedge clk_i);
        m_arvalid = other;
        #1 check("arready_busy", m_arready, 2'b00);
        if (!err) begin
            check("arvalid_1st", s_arvalid, 1'b1);
            check("araddr", s_araddr, addr);
            check("arlen", s_arlen, len);
            check("arid", s_arid, 4'(m));
            @(negedge clk_i);
            #1 check("arvalid_hold", s_arvalid, 1'b1);
            check("araddr_hold", s_araddr, addr);
            s_arready = 1'b1;
            @(negedge clk_i);
            s_arready = 1'b0;
        end else begin
            check("err_no_arvalid", s_arvalid, 1'b0);
        end
        beat   = 0;
        stalls = 0;
        while (beat <= len) begin
            stalled  = (beat == stall_beat) && (stalls < 3);
            m_rready = stalled ? 2'b00 : me;
            s_rvalid = !err;
            s_rdata  = pat(m, beat);
            s_rlast  = (beat == len);
            s_rid    = rid;
            s_rresp  = sresp;
            #1 check("rvalid", m_rvalid, me);
            if (err) begin
                check("err_rdata", m_rdata, 256'd0);
                check("err_rresp", m_rresp, 2'b11);
                check("err_rlast", m_rlast, beat == len);
                check("err_arvalid", s_arvalid, 1'b0);
                check("err_srready", s_rready, 1'b0);
            end else begin
                check("rdata", m_rdata, pat(m, beat));
                check("rlast", m_rlast, beat == len);
                check("rresp", m_rresp, exp_resp);
                check("srready", s_rready, !stalled);
            end
            if (stalled) stalls++;
            else beat++;
            @(negedge clk_i);
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        m_rready = 2'b00;
        #1 check("idle_rvalid", m_rvalid, 2'b00);
        check("idle_rlast", m_rlast, 1'b0);
        check("idle_srready", s_rready, 1'b0);
        check("idle_rdata", m_rdata, 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        m_arvalid = 2'b00; m_araddr = '0; m_arlen = '0; m_rready = 2'b00;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
        s_rresp = 2'b00; s_rid = 4'd0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_arvalid", s_arvalid, 1'b0);
        check("rst_araddr", s_araddr, 32'd0);
        check("rst_arid", s_arid, 4'd0);
        check("rst_rvalid", m_rvalid, 2'b00);
        check("rst_arready", m_arready, 2'b00);
        check("rst_rresp", m_rresp, 2'b00);
        check("arsize", s_arsize, 3'd5);
        check("arburst", s_arburst, 2'b01);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;

        // single read, master 0
        run_burst(0, 32'h8000_0040, 3, 4'd0, 2'b00, 1'b0, 2'b00, -1);

        // asynchronous reset in the middle of DATA
        m_arvalid = 2'b01; m_araddr[31:0] = 32'h8000_0100; m_arlen[7:0] = 8'd7;
        @(negedge clk_i);
        m_arvalid = 2'b00; s_arready = 1'b1;
        @(negedge clk_i);
        s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b01; s_rdata = pat(0, 0); s_rid = 4'd0;
        #1 check("pre_rst_rvalid", m_rvalid, 2'b01);
        #2 rst_i = 1'b1; m_arvalid = 2'b01;
        #1 check("arst_arvalid", s_arvalid, 1'b0);
        check("arst_rvalid", m_rvalid, 2'b00);
        check("arst_arready", m_arready, 2'b00);
        check("arst_srready", s_rready, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0; m_arvalid = 2'b00;
        #1 check("post_rst_rvalid", m_rvalid, 2'b00);
        check("post_rst_srready", s_rready, 1'b0);
        check("post_rst_arvalid", s_arvalid, 1'b0);
        s_rvalid = 1'b0; m_rready = 2'b00;

        // contention and strict alternation
        run_burst(0, 32'h8000_0200, 1, 4'd0, 2'b00, 1'b0, 2'b10, -1);
        run_burst(1, 32'h8020_0000, 1, 4'd1, 2'b00, 1'b0, 2'b00, -1);
        run_burst(0, 32'h8000_0300, 0, 4'd0, 2'b00, 1'b0, 2'b10, -1);
        run_burst(1, 32'h8020_0100, 0, 4'd1, 2'b00, 1'b0, 2'b01, -1);
        run_burst(0, 32'h8000_0400, 0, 4'd0, 2'b00, 1'b0, 2'b00, -1);

        // decode error and window boundaries
        run_burst(1, 32'h9000_0000, 1, 4'd1, 2'b00, 1'b1, 2'b00, -1);
        run_burst(0, 32'h8000_FFE0, 0, 4'd0, 2'b00, 1'b0, 2'b00, -1);
        run_burst(1, 32'h8001_0000, 0, 4'd1, 2'b00, 1'b1, 2'b00, -1);
        run_burst(0, 32'h7FFF_FFFF, 2, 4'd0, 2'b00, 1'b1, 2'b00, 1);
        run_burst(1, 32'h8020_FFFF, 0, 4'd1, 2'b00, 1'b0, 2'b00, -1);
        run_burst(0, 32'h8021_0000, 0, 4'd0, 2'b00, 1'b1, 2'b00, -1);

        // backpressure, response forwarding, ID mismatch
        run_burst(0, 32'h8000_0080, 3, 4'd0, 2'b00, 1'b0, 2'b00, 1);
        run_burst(1, 32'h8020_0040, 1, 4'd1, 2'b01, 1'b0, 2'b00, -1);
        run_burst(0, 32'h8000_0000, 2, 4'd1, 2'b00, 1'b0, 2'b00, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
